hack_cpu: RTL and testbench
===========================

Name: hack_cpu

Overview:
- Hack CPU datapath and control. Sits directly upstream of the 16-bit Hack ALU and drives its six control bits and both operands.
- Holds the A, D and PC registers and decodes A- and C-instructions.
- Single-cycle: one instruction per enabled clock edge.
- Connects to instruction ROM (via pc) and data RAM (via addressM, outM, writeM, inM).

Parameters:
- WIDTH, 16, data/instruction width; only 16 is supported.
- PC_WIDTH, 15, program counter and data address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- en  in  1  clock enable (memory-wait stall). 0 means hold all state.
- instruction  in  16  current instruction word from ROM[pc].
- inM  in  16  data RAM read value at addressM.
- outM  out  16  ALU result (combinational).
- writeM  out  1  RAM write strobe for the current cycle.
- addressM  out  15  RAM address, equal to A[14:0].
- pc  out  15  address of the next instruction to fetch.
- dbg_a  out  16  A register, for verification.
- dbg_d  out  16  D register, for verification.

Behaviour:
- Reset: on a clk edge with rst_n=0, A=0, D=0, PC=0. Reset has priority over en.
- While rst_n=0, writeM is forced to 0.
- After reset: pc=0, addressM=0, dbg_a=0, dbg_d=0.
- Decode:
  - instruction[15]=0 is an A-instruction: A <= instruction. D is unchanged, writeM=0, PC <= PC+1.
  - instruction[15]=1 is a C-instruction. Bits [14:13] are ignored. [12]=a. [11:6]=zx,nx,zy,ny,f,no. [5:3]=dA,dD,dM. [2:0]=j1 (out<0), j2 (out=0), j3 (out>0).
- ALU hookup: instantiate the existing alu with port order (x, y, zx, nx, zy, ny, f, no, out, zr, ng).
  - x = D.
  - y = a ? inM : A.
  - For A-instructions the control bits are don't-care.
- outM = ALU out, always driven, including during A-instructions.
- writeM = rst_n & en & instruction[15] & dM.
- Register updates (C-instruction, en=1):
  - A <= out if dA.
  - D <= out if dD.
  - Both are written from the same result when dA and dD are both set.
- Jump: taken = (j1&ng) | (j2&zr) | (j3&~ng&~zr).
  - Taken: PC <= A[14:0], using the pre-edge A value even when dA=1 in the same instruction.
  - Not taken: PC <= PC+1.
  - j=111 jumps unconditionally; j=000 never jumps.
- Operands always use pre-edge register values: D read and D write in the same instruction uses the old D.
- addressM reflects the pre-edge A for the whole cycle. For AM=..., the RAM write targets the old A.
- PC+1 wraps modulo 2^15: 0x7FFF goes to 0x0000.
- en=0: A, D and PC hold, writeM=0. outM still follows the combinational ALU result.
- Reset mid-sequence: the next edge with rst_n=0 clears state regardless of the instruction. Execution restarts at pc=0 on the first edge with rst_n=1.
- No internal pipeline: latency from instruction presentation to register update is 1 edge.

Test Plan:
1. Reset: rst_n=0 for 2 edges with instruction=0xFFFF and en=1 → pc=0, dbg_a=0, dbg_d=0, writeM=0 throughout. Then rst_n=1 with instruction=0x0005 → after 1 edge, dbg_a=5, pc=1.
2. Add and store: execute 0x0002 (@2), 0xEC10 (D=A), 0x0003 (@3), 0xE090 (D=D+A), 0x0000 (@0), then 0xE308 (M=D).
   - During M=D: addressM=0, outM=5, writeM=1.
   - After the sequence: dbg_d=5, pc=6.
3. Unconditional jump: 0x0007 then 0xEA87 (0;JMP) → pc=7 after the second edge, writeM=0, D unchanged.
4. Conditional jumps with D=0:
   - 0x0009 then 0xE301 (D;JGT) → pc increments, no jump.
   - Then 0x0009 then 0xE302 (D;JEQ) → pc=9.
5. Memory read-modify-write: A=0x0010, inM=0x0009, instruction 0xFDE8 (AM=M+1).
   - In that cycle: outM=0x000A, writeM=1, addressM=0x0010.
   - After the edge: dbg_a=0x000A.
   - Follow with 0xEA87: pc=0x000A, confirming the jump uses the new A in the following instruction.
6. Stall and wrap:
   - Hold en=0 for 3 edges with 0xEA87 → pc, A and D unchanged, writeM=0 each cycle.
   - Separately, jump to pc=0x7FFF, then an A-instruction → pc=0x0000.

Source files
------------

// File: rtl/hack_cpu.sv
// Hack CPU: A/D/PC registers, A/C-instruction decode and jump logic driving a 16-bit Hack ALU.
// One instruction retires per enabled rising edge; outM, writeM and addressM are combinational.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
  end
endmodule

module hack_cpu #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [WIDTH-1:0]    instruction,
  input  logic [WIDTH-1:0]    inM,
  output logic [WIDTH-1:0]    outM,
  output logic                writeM,
  output logic [PC_WIDTH-1:0] addressM,
  output logic [PC_WIDTH-1:0] pc,
  output logic [WIDTH-1:0]    dbg_a,
  output logic [WIDTH-1:0]    dbg_d
);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  logic [WIDTH-1:0]    a_q, d_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [WIDTH-1:0]    alu_y, alu_out;
  logic                alu_zr, alu_ng;
  logic                is_c, dest_a, dest_d, dest_m, jump_taken;
  logic [1:0]          unused_bits;

  assign is_c        = instruction[15];
  assign dest_a      = instruction[5];
  assign dest_d      = instruction[4];
  assign dest_m      = instruction[3];
  assign unused_bits = instruction[14:13];

  // Operands always come from pre-edge register values.
  assign alu_y = instruction[12] ? inM : a_q;

  alu #(.WIDTH(WIDTH)) u_alu (
    .x   (d_q),
    .y   (alu_y),
    .zx  (instruction[11]),
    .nx  (instruction[10]),
    .zy  (instruction[9]),
    .ny  (instruction[8]),
    .f   (instruction[7]),
    .no  (instruction[6]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump_taken = is_c & ((instruction[2] & alu_ng) |
                              (instruction[1] & alu_zr) |
                              (instruction[0] & ~alu_ng & ~alu_zr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= '0;
    end else if (en) begin
      if (!is_c) begin
        a_q <= instruction;
      end else if (dest_a) begin
        a_q <= alu_out;
      end
      if (is_c && dest_d) begin
        d_q <= alu_out;
      end
      // Jump target is the A value before this edge, even when dest_a also writes A.
      pc_q <= jump_taken ? a_q[PC_WIDTH-1:0] : pc_q + PC_ONE;
    end
  end

  assign outM     = alu_out;
  assign writeM   = rst_n & en & is_c & dest_m;
  assign addressM = a_q[PC_WIDTH-1:0];
  assign pc       = pc_q;
  assign dbg_a    = a_q;
  assign dbg_d    = d_q;
endmodule

// File: tb/tb_hack_cpu.sv
// Bench for hack_cpu: directed vector table, hand-written corner sequences, then random
// instructions checked against a mnemonic-level Hack machine model.
module tb_hack_cpu;
  localparam int SW = 47;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;
  logic [15:0] dbg_a;
  logic [15:0] dbg_d;

  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];

  // Model state
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;

  hack_cpu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc),
    .dbg_a       (dbg_a),
    .dbg_d       (dbg_d)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] inm;
    logic        en;
    logic        rst_n;
    logic        chk_out;
    logic [15:0] out;
    logic        wr;
    logic [14:0] addr;
    logic [15:0] a;
    logic [15:0] d;
    logic [14:0] pc;
  } vec_t;

  vec_t tbl[26];

  logic [5:0] comp_codes[18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                 6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                 6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                 6'b000111, 6'b000000, 6'b010101};

  function automatic vec_t mk(input logic [15:0] ins, input logic [15:0] inm, input logic e,
                              input logic r, input logic co, input logic [15:0] o,
                              input logic w, input logic [14:0] ad, input logic [15:0] a,
                              input logic [15:0] d, input logic [14:0] p);
    vec_t v;
    v.ins = ins; v.inm = inm; v.en = e; v.rst_n = r; v.chk_out = co; v.out = o;
    v.wr = w; v.addr = ad; v.a = a; v.d = d; v.pc = p;
    return v;
  endfunction

  // Hack assembly comp mnemonics evaluated directly (y is A or M).
  function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] d,
                                           input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return d;
      6'b110000: return y;
      6'b001101: return ~d;
      6'b110001: return ~y;
      6'b001111: return 16'd0 - d;
      6'b110011: return 16'd0 - y;
      6'b011111: return d + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return d - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return d + y;
      6'b010011: return d - y;
      6'b000111: return y - d;
      6'b000000: return d & y;
      6'b010101: return d | y;
      default:   return 16'd0;
    endcase
  endfunction

  // Computes this cycle's combinational expectations, then advances the model one edge.
  task automatic model_step(input logic [15:0] ins, input logic [15:0] inm, input logic e,
                            input logic r, output logic [15:0] o, output logic w,
                            output logic [14:0] ad);
    logic [15:0] res;
    logic        take;
    res  = ref_comp(ins[11:6], m_d, ins[12] ? inm : m_a);
    o    = res;
    w    = r && e && ins[15] && ins[3];
    ad   = m_a[14:0];
    take = ins[15] && ((ins[2] && $signed(res) < 0) || (ins[1] && res == 16'd0) ||
                       (ins[0] && $signed(res) > 0));
    if (!r) begin
      m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0;
    end else if (e) begin
      m_pc = take ? m_a[14:0] : m_pc + 15'd1;
      if (!ins[15]) m_a = ins;
      else begin
        if (ins[5]) m_a = res;
        if (ins[4]) m_d = res;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: inputs applied just after an edge, outputs sampled at negedge and after next edge.
  task automatic drive(input string tag, input logic [15:0] ins, input logic [15:0] inm,
                       input logic e, input logic r, input logic co, input logic [15:0] o,
                       input logic w, input logic [14:0] ad, input logic [15:0] xa,
                       input logic [15:0] xd, input logic [14:0] xp);
    logic [SW-1:0] s;
    instruction = ins; inM = inm; en = e; rst_n = r;
    exp_q.push_back({xa, xd, xp});
    @(negedge clk);
    if (co) check({tag, " outM"}, 32'(outM), 32'(o));
    check({tag, " writeM"}, 32'(writeM), 32'(w));
    check({tag, " addressM"}, 32'(addressM), 32'(ad));
    @(posedge clk);
    #1;
    s = exp_q.pop_front();
    check({tag, " dbg_a"}, 32'(dbg_a), 32'(s[46:31]));
    check({tag, " dbg_d"}, 32'(dbg_d), 32'(s[30:15]));
    check({tag, " pc"}, 32'(pc), 32'(s[14:0]));
  endtask

  task automatic drive_model(input string tag, input logic [15:0] ins, input logic [15:0] inm,
                             input logic e, input logic r);
    logic [15:0] o;
    logic        w;
    logic [14:0] ad;
    model_step(ins, inm, e, r, o, w, ad);
    drive(tag, ins, inm, e, r, ins[15], o, w, ad, m_a, m_d, m_pc);
  endtask

  initial begin
    tbl[0]  = mk(16'hFFFF, 16'h0, 1, 0, 0, 16'h0,    0, 15'h0,    16'h0,    16'h0,    15'h0);
    tbl[1]  = mk(16'hFFFF, 16'h0, 1, 0, 0, 16'h0,    0, 15'h0,    16'h0,    16'h0,    15'h0);
    tbl[2]  = mk(16'h0005, 16'h0, 1, 1, 0, 16'h0,    0, 15'h0,    16'h5,    16'h0,    15'h1);
    tbl[3]  = mk(16'h0000, 16'h0, 1, 0, 0, 16'h0,    0, 15'h5,    16'h0,    16'h0,    15'h0);
    tbl[4]  = mk(16'h0002, 16'h0, 1, 1, 0, 16'h0,    0, 15'h0,    16'h2,    16'h0,    15'h1);
    tbl[5]  = mk(16'hEC10, 16'h0, 1, 1, 1, 16'h2,    0, 15'h2,    16'h2,    16'h2,    15'h2);
    tbl[6]  = mk(16'h0003, 16'h0, 1, 1, 0, 16'h0,    0, 15'h2,    16'h3,    16'h2,    15'h3);
    tbl[7]  = mk(16'hE090, 16'h0, 1, 1, 1, 16'h5,    0, 15'h3,    16'h3,    16'h5,    15'h4);
    tbl[8]  = mk(16'h0000, 16'h0, 1, 1, 0, 16'h0,    0, 15'h3,    16'h0,    16'h5,    15'h5);
    tbl[9]  = mk(16'hE308, 16'h0, 1, 1, 1, 16'h5,    1, 15'h0,    16'h0,    16'h5,    15'h6);
    tbl[10] = mk(16'h0007, 16'h0, 1, 1, 0, 16'h0,    0, 15'h0,    16'h7,    16'h5,    15'h7);
    tbl[11] = mk(16'hEA87, 16'h0, 1, 1, 1, 16'h0,    0, 15'h7,    16'h7,    16'h5,    15'h7);
    tbl[12] = mk(16'hEA90, 16'h0, 1, 1, 1, 16'h0,    0, 15'h7,    16'h7,    16'h0,    15'h8);
    tbl[13] = mk(16'h0009, 16'h0, 1, 1, 0, 16'h0,    0, 15'h7,    16'h9,    16'h0,    15'h9);
    tbl[14] = mk(16'hE301, 16'h0, 1, 1, 1, 16'h0,    0, 15'h9,    16'h9,    16'h0,    15'hA);
    tbl[15] = mk(16'h0009, 16'h0, 1, 1, 0, 16'h0,    0, 15'h9,    16'h9,    16'h0,    15'hB);
    tbl[16] = mk(16'hE302, 16'h0, 1, 1, 1, 16'h0,    0, 15'h9,    16'h9,    16'h0,    15'h9);
    tbl[17] = mk(16'h0010, 16'h0, 1, 1, 0, 16'h0,    0, 15'h9,    16'h10,   16'h0,    15'hA);
    tbl[18] = mk(16'hFDE8, 16'h9, 1, 1, 1, 16'hA,    1, 15'h10,   16'hA,    16'h0,    15'hB);
    tbl[19] = mk(16'hEA87, 16'h0, 1, 1, 1, 16'h0,    0, 15'hA,    16'hA,    16'h0,    15'hA);
    tbl[20] = mk(16'hEA87, 16'h0, 0, 1, 1, 16'h0,    0, 15'hA,    16'hA,    16'h0,    15'hA);
    tbl[21] = mk(16'hEA87, 16'h0, 0, 1, 1, 16'h0,    0, 15'hA,    16'hA,    16'h0,    15'hA);
    tbl[22] = mk(16'hEA8F, 16'h0, 0, 1, 1, 16'h0,    0, 15'hA,    16'hA,    16'h0,    15'hA);
    tbl[23] = mk(16'h7FFF, 16'h0, 1, 1, 0, 16'h0,    0, 15'hA,    16'h7FFF, 16'h0,    15'hB);
    tbl[24] = mk(16'hEA87, 16'h0, 1, 1, 1, 16'h0,    0, 15'h7FFF, 16'h7FFF, 16'h0,    15'h7FFF);
    tbl[25] = mk(16'h0001, 16'h0, 1, 1, 0, 16'h0,    0, 15'h7FFF, 16'h1,    16'h0,    15'h0);

    instruction = 16'hFFFF; inM = 16'h0; en = 1'b1; rst_n = 1'b0;
    m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      logic [15:0] o;
      logic        w;
      logic [14:0] ad;
      model_step(tbl[i].ins, tbl[i].inm, tbl[i].en, tbl[i].rst_n, o, w, ad);
      drive($sformatf("vec%0d", i), tbl[i].ins, tbl[i].inm, tbl[i].en, tbl[i].rst_n,
            tbl[i].chk_out, tbl[i].out, tbl[i].wr, tbl[i].addr, tbl[i].a, tbl[i].d, tbl[i].pc);
    end

    // AD=-1;JMP jumps to the old A; then D=D+1 reads the old D in the same cycle.
    drive("seq_at32", 16'h0020, 16'h0, 1, 1, 0, 16'h0,    0, 15'h1,  16'h20,   16'h0,    15'h1);
    drive("seq_adjmp", 16'hEEB7, 16'h0, 1, 1, 1, 16'hFFFF, 0, 15'h20, 16'hFFFF, 16'hFFFF, 15'h20);
    drive("seq_dinc", 16'hE7D0, 16'h0, 1, 1, 1, 16'h0,    0, 15'h7FFF, 16'hFFFF, 16'h0,   15'h21);
    m_a = 16'hFFFF; m_d = 16'h0; m_pc = 15'h21;

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      logic        e, r;
      if ($urandom_range(1, 0) == 0) begin
        ins = {1'b0, 15'($urandom_range(32767, 0))};
      end else begin
        ins = {1'b1, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
               comp_codes[$urandom_range(17, 0)], 3'($urandom_range(7, 0)),
               3'($urandom_range(7, 0))};
      end
      e = ($urandom_range(9, 0) != 0);
      r = ($urandom_range(39, 0) != 0);
      drive_model($sformatf("rnd%0d", i), ins, 16'($urandom_range(65535, 0)), e, r);
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
